// File: rtl/song_reader.sv
// rtl/song_reader.sv - note sequencer that walks a song ROM and issues note commands to chords
//
// Reads one entry per fetch from an external synchronous song ROM (one cycle of
// read latency) and acts on it:
//   note entry     {0, note!=0, dur} : latch note/duration, strobe new_note once
//   advance entry  {1, 0, D>0}       : hold the sequence for D beats
//   end marker     {0, 0, 0}         : strobe song_done, park in DONE
//   skipped        {1, x, 0}, {0, 0, dur!=0} : move to the next entry silently
// Walking past the last index of a song also ends it (no wrap to entry 0).
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   play       in   1 = run, 0 = freeze state, counters and strobes
//   song       in   song select; a change restarts the reader from IDLE
//   beat       in   one-cycle beat pulse used to time advance entries
//   rom_addr   out  {song_q, idx}, registered
//   rom_data   in   {advance, note, duration}, valid one cycle after rom_addr
//   note       out  last issued note, registered and held
//   duration   out  last issued duration, registered and held
//   new_note   out  one-cycle strobe: note/duration are a fresh command
//   song_done  out  one-cycle strobe, registered, on entering DONE

module song_reader #(
    parameter int SONG_W = 2,
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    input  logic                    beat,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W:0]   rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    new_note,
    output logic                    song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_DECODE,
        S_NOTE_OUT,
        S_WAIT_BEATS,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    // Registered state
    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [DUR_W-1:0]          r_beat_cnt;
    logic [DUR_W-1:0]          r_wait_d;
    logic [SONG_W-1:0]         r_song_q;
    logic [SONG_W+IDX_W-1:0]   r_rom_addr;
    logic [NOTE_W-1:0]         r_note;
    logic [DUR_W-1:0]          r_duration;
    logic                      r_song_done;

    // Next-state values
    state_t                    w_state_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [DUR_W-1:0]          w_beat_cnt_nxt;
    logic [DUR_W-1:0]          w_wait_d_nxt;
    logic [SONG_W-1:0]         w_song_q_nxt;
    logic [SONG_W+IDX_W-1:0]   w_rom_addr_nxt;
    logic [NOTE_W-1:0]         w_note_nxt;
    logic [DUR_W-1:0]          w_duration_nxt;
    logic                      w_song_done_nxt;
    logic                      w_step;

    // Fields of the entry currently presented by the ROM
    logic                      w_ent_adv;
    logic [NOTE_W-1:0]         w_ent_note;
    logic [DUR_W-1:0]          w_ent_dur;

    logic                      w_song_chg;
    logic                      w_run;
    logic [DUR_W-1:0]          w_beat_inc;

    assign w_ent_adv  = rom_data[NOTE_W+DUR_W];
    assign w_ent_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_ent_dur  = rom_data[DUR_W-1:0];

    // IDLE tracks the song input itself, so a mismatch only matters elsewhere.
    assign w_song_chg = (r_state != S_IDLE) && (song != r_song_q);
    assign w_run      = play && !w_song_chg;

    // beat_cnt never exceeds D-1 here, so the increment cannot overflow.
    assign w_beat_inc = r_beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_beat_cnt  <= '0;
            r_wait_d    <= '0;
            r_song_q    <= '0;
            r_rom_addr  <= '0;
            r_note      <= '0;
            r_duration  <= '0;
            r_song_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_wait_d    <= w_wait_d_nxt;
            r_song_q    <= w_song_q_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_note      <= w_note_nxt;
            r_duration  <= w_duration_nxt;
            r_song_done <= w_song_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_wait_d_nxt    = r_wait_d;
        w_song_q_nxt    = r_song_q;
        w_rom_addr_nxt  = r_rom_addr;
        w_note_nxt      = r_note;
        w_duration_nxt  = r_duration;
        w_song_done_nxt = 1'b0;
        w_step          = 1'b0;

        if (w_song_chg) begin
            // Restart wins over everything, even while paused.
            w_state_nxt    = S_IDLE;
            w_idx_nxt      = '0;
            w_beat_cnt_nxt = '0;
        end else if (r_state == S_IDLE) begin
            w_song_q_nxt = song;
            w_idx_nxt    = '0;
            if (play) begin
                w_state_nxt = S_FETCH;
            end
        end else if (play) begin
            case (r_state)
                S_FETCH: begin
                    w_rom_addr_nxt = {r_song_q, r_idx};
                    w_state_nxt    = S_WAIT_ROM;
                end
                S_WAIT_ROM: begin
                    w_state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (!w_ent_adv) begin
                        if (w_ent_note != '0) begin
                            w_note_nxt     = w_ent_note;
                            w_duration_nxt = w_ent_dur;
                            w_state_nxt    = S_NOTE_OUT;
                        end else if (w_ent_dur == '0) begin
                            w_song_done_nxt = 1'b1;
                            w_state_nxt     = S_DONE;
                        end else begin
                            w_step = 1'b1;
                        end
                    end else if (w_ent_dur == '0) begin
                        w_step = 1'b1;
                    end else begin
                        // A beat arriving in this cycle is deliberately ignored.
                        w_beat_cnt_nxt = '0;
                        w_wait_d_nxt   = w_ent_dur;
                        w_state_nxt    = S_WAIT_BEATS;
                    end
                end
                S_NOTE_OUT: begin
                    w_step = 1'b1;
                end
                S_WAIT_BEATS: begin
                    if (beat) begin
                        w_beat_cnt_nxt = w_beat_inc;
                        if (w_beat_inc == r_wait_d) begin
                            w_step = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            // Moving past an entry: the last index ends the song instead of wrapping.
            if (w_step) begin
                if (r_idx == IDX_LAST) begin
                    w_song_done_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign note      = r_note;
    assign duration  = r_duration;
    assign song_done = r_song_done;
    assign new_note  = (r_state == S_NOTE_OUT) && w_run;

endmodule
